// File: rtl/gf_pkg.sv
// Shared GF(2^16) definitions for the multiplier array: field constants, lane word type,
// and the digit-serial multiply / reduce helpers used by every pipeline stage.
package gf_pkg;

    localparam int unsigned GF_M     = 16;
    localparam int unsigned GF_DIGIT = 8;
    localparam int unsigned GF_LANES = 9;
    localparam logic [16:0] GF_POLY  = 17'h1002B;

    // Index 0 holds the x^15 coefficient.
    typedef logic [0:GF_M-1]          gf_elem_t;
    typedef logic [0:GF_M+GF_DIGIT-1] gf_wide_t;

    function automatic gf_wide_t gf_clmul_digit(input gf_elem_t a, input logic [0:GF_DIGIT-1] b);
        gf_wide_t acc;
        acc = '0;
        for (int unsigned i = 0; i < GF_DIGIT; i++) begin
            if (b[GF_DIGIT-1-i]) begin
                acc = acc ^ (gf_wide_t'(a) << i);
            end
        end
        return acc;
    endfunction

    // Two folds of x^16 = poly[15:0] bring any 24-bit product back below degree 16.
    function automatic gf_elem_t gf_reduce(input gf_wide_t p, input logic [16:0] poly);
        gf_wide_t acc;
        gf_wide_t hi;
        acc = p;
        for (int unsigned fold = 0; fold < 2; fold++) begin
            hi  = acc >> GF_M;
            acc = acc ^ (hi << GF_M);
            for (int unsigned j = 0; j < GF_M; j++) begin
                if (poly[j]) begin
                    acc = acc ^ (hi << j);
                end
            end
        end
        return acc[GF_DIGIT:GF_M+GF_DIGIT-1];
    endfunction

endpackage

// File: rtl/gf_mul_lane.sv
// One GF(2^16) multiplier lane: input register, high-digit partial product,
// then low-digit partial product merged with the shifted high result.
module gf_mul_lane
    import gf_pkg::*;
#(
    parameter int unsigned DIGIT = GF_DIGIT,
    parameter logic [16:0] POLY  = GF_POLY
) (
    input  logic     clk,
    input  logic     rst,
    input  gf_elem_t o,
    input  gf_elem_t t,
    output gf_elem_t r
);

    gf_elem_t         o0, t0;
    gf_elem_t         o1, acc1;
    logic [0:DIGIT-1] tl1;
    gf_elem_t         r_q;
    gf_elem_t         acc1_d, acc2_d;

    // Reduction is linear, so (acc1*x^8 mod P) ^ (o*tl mod P) is folded in a single pass.
    always_comb begin
        acc1_d = gf_reduce(gf_clmul_digit(o0, t0[0:DIGIT-1]), POLY);
        acc2_d = gf_reduce(gf_wide_t'({acc1, {DIGIT{1'b0}}}) ^ gf_clmul_digit(o1, tl1), POLY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o0   <= '0;
            t0   <= '0;
            o1   <= '0;
            tl1  <= '0;
            acc1 <= '0;
            r_q  <= '0;
        end else begin
            o0   <= o;
            t0   <= t;
            o1   <= o0;
            tl1  <= t0[DIGIT:GF_M-1];
            acc1 <= acc1_d;
            r_q  <= acc2_d;
        end
    end

    assign r = r_q;

endmodule

// File: rtl/gf_mul_array.sv
// Nine-lane GF(2^16) multiplier array with a fixed 3-cycle latency; the valid tag
// travels in a shift register alongside the lane pipelines.
module gf_mul_array
    import gf_pkg::*;
#(
    parameter int unsigned LANES = GF_LANES,
    parameter int unsigned M     = GF_M,
    parameter int unsigned DIGIT = GF_DIGIT,
    parameter logic [16:0] POLY  = GF_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [0:M-1] mul1_o_in,
    input  logic [0:M-1] mul2_o_in,
    input  logic [0:M-1] mul3_o_in,
    input  logic [0:M-1] mul4_o_in,
    input  logic [0:M-1] mul5_o_in,
    input  logic [0:M-1] mul6_o_in,
    input  logic [0:M-1] mul7_o_in,
    input  logic [0:M-1] mul8_o_in,
    input  logic [0:M-1] mul9_o_in,
    input  logic [0:M-1] mul1_t_in,
    input  logic [0:M-1] mul2_t_in,
    input  logic [0:M-1] mul3_t_in,
    input  logic [0:M-1] mul4_t_in,
    input  logic [0:M-1] mul5_t_in,
    input  logic [0:M-1] mul6_t_in,
    input  logic [0:M-1] mul7_t_in,
    input  logic [0:M-1] mul8_t_in,
    input  logic [0:M-1] mul9_t_in,
    output logic [0:M-1] mul1_r_dat,
    output logic [0:M-1] mul2_r_dat,
    output logic [0:M-1] mul3_r_dat,
    output logic [0:M-1] mul4_r_dat,
    output logic [0:M-1] mul5_r_dat,
    output logic [0:M-1] mul6_r_dat,
    output logic [0:M-1] mul7_r_dat,
    output logic [0:M-1] mul8_r_dat,
    output logic [0:M-1] mul9_r_dat,
    output logic         out_valid
);

    gf_elem_t   o_lane [LANES];
    gf_elem_t   t_lane [LANES];
    gf_elem_t   r_lane [LANES];
    logic [0:2] v_q;

    assign o_lane[0] = mul1_o_in;
    assign o_lane[1] = mul2_o_in;
    assign o_lane[2] = mul3_o_in;
    assign o_lane[3] = mul4_o_in;
    assign o_lane[4] = mul5_o_in;
    assign o_lane[5] = mul6_o_in;
    assign o_lane[6] = mul7_o_in;
    assign o_lane[7] = mul8_o_in;
    assign o_lane[8] = mul9_o_in;

    assign t_lane[0] = mul1_t_in;
    assign t_lane[1] = mul2_t_in;
    assign t_lane[2] = mul3_t_in;
    assign t_lane[3] = mul4_t_in;
    assign t_lane[4] = mul5_t_in;
    assign t_lane[5] = mul6_t_in;
    assign t_lane[6] = mul7_t_in;
    assign t_lane[7] = mul8_t_in;
    assign t_lane[8] = mul9_t_in;

    assign mul1_r_dat = r_lane[0];
    assign mul2_r_dat = r_lane[1];
    assign mul3_r_dat = r_lane[2];
    assign mul4_r_dat = r_lane[3];
    assign mul5_r_dat = r_lane[4];
    assign mul6_r_dat = r_lane[5];
    assign mul7_r_dat = r_lane[6];
    assign mul8_r_dat = r_lane[7];
    assign mul9_r_dat = r_lane[8];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        gf_mul_lane #(
            .DIGIT (DIGIT),
            .POLY  (POLY)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .o   (o_lane[g]),
            .t   (t_lane[g]),
            .r   (r_lane[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= {in_valid, v_q[0:1]};
        end
    end

    assign out_valid = v_q[2];

endmodule
